fifo_wr_ptr_full: RTL and testbench
===================================

Name: fifo_wr_ptr_full

Overview:
Write-side pointer and flag controller for the dual-clock FIFO, running entirely in the write clock domain.
- Generates the binary memory write address and write enable for the FIFO memory.
- Produces the registered Gray-coded write pointer that crosses into the read domain through the two-flop pointer synchronizer.
- Consumes the read pointer already synchronized into this domain and produces FULL, ALMOST_FULL and a fill level.

Parameters:
ADD_WIDTH, 3, memory address width; FIFO depth = 2^ADD_WIDTH; pointer width = ADD_WIDTH+1
AF_THRESH, 6, fill level at or above which ALMOST_FULL asserts; legal range 1..2^ADD_WIDTH

Ports:
CLK  input  1  write-domain clock, all logic on rising edge
RST  input  1  reset, active-low, synchronous
W_INC  input  1  write request from producer, one entry per cycle
SYNC_RD_PTR  input  ADD_WIDTH+1  read pointer (Gray code) already synchronized into the CLK domain
W_ADDR  output  ADD_WIDTH  memory write address = low ADD_WIDTH bits of binary write pointer
W_EN  output  1  memory write enable
GRAY_WR_PTR  output  ADD_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer
FULL  output  1  FIFO full, registered
ALMOST_FULL  output  1  level >= AF_THRESH, registered
WR_LEVEL  output  ADD_WIDTH+1  registered occupancy seen from the write side (0..2^ADD_WIDTH)

Behaviour:
- Reset: one clock is synchronous and active-low, with ports named CLK and RST. On a rising CLK edge with RST=0, all registers clear: W_ADDR=0, GRAY_WR_PTR=0, FULL=0, ALMOST_FULL=0, WR_LEVEL=0. W_EN is combinational and is 0 while W_INC=0. Reset mid-operation discards all state with no special sequencing; a write accepted in the same cycle is dropped.
- Internal binary pointer wbin, ADD_WIDTH+1 bits. wbin_next = wbin + W_EN, wrapping modulo 2^(ADD_WIDTH+1).
- W_EN = W_INC & ~FULL (combinational). A write requested while FULL=1 is ignored and all pointers hold.
- gray_next = wbin_next ^ (wbin_next >> 1). GRAY_WR_PTR <= gray_next. The Gray register is the only signal sent across domains, so it must be driven directly from a flop with no logic after it.
- W_ADDR = wbin[ADD_WIDTH-1:0]. The address wraps modulo 2^ADD_WIDTH.
- FULL <= (gray_next == {~SYNC_RD_PTR[MSB:MSB-1], SYNC_RD_PTR[MSB-2:0]}).
  - FULL asserts on the same edge that accepts the final write, so there is zero-cycle latency to block the next write.
  - FULL deasserts on the first edge after SYNC_RD_PTR advances.
- rbin = Gray-to-binary of SYNC_RD_PTR (combinational XOR prefix).
- WR_LEVEL <= wbin_next - rbin, modulo 2^(ADD_WIDTH+1).
- ALMOST_FULL <= (wbin_next - rbin) >= AF_THRESH.
- Simultaneous write and SYNC_RD_PTR change: both are applied in the same cycle and flags reflect both.
- Level and flags are pessimistic because the read pointer is two or more cycles stale. FULL may be held longer than necessary, but it must never release early.

Optional Feature:
Macro FIFO_WR_OVF_EN.
- When defined: adds output port OVERFLOW (1 bit, registered, sticky).
  - Set on any edge where W_INC=1 and FULL=1.
  - Cleared only by reset.
  - Reset value 0.
- When undefined: the OVERFLOW port and its logic are absent, and attempted writes while full are silently ignored.

Test Plan:
- Reset: RST=0 for one edge with W_INC=1 -> all outputs 0, GRAY_WR_PTR=4'b0000, no address advance.
- Fill, SYNC_RD_PTR=0000, 8 back-to-back writes:
  - W_ADDR steps 0..7.
  - GRAY_WR_PTR steps 0001,0011,0010,0110,0111,0101,0100,1100.
  - ALMOST_FULL=1 after 6th edge.
  - FULL=1 and WR_LEVEL=8 after 8th edge.
- Write while full: W_INC=1 with FULL=1 -> W_EN=0, GRAY_WR_PTR holds 1100, W_ADDR holds 0; OVERFLOW=1 if FIFO_WR_OVF_EN is defined.
- Drain one entry, then refill:
  - SYNC_RD_PTR=0001 -> next edge FULL=0, WR_LEVEL=7.
  - One write -> W_ADDR=0 is written; GRAY_WR_PTR=1101, FULL=1, WR_LEVEL=8.
- Wraparound: 20 writes with SYNC_RD_PTR tracking two writes behind -> binary pointer wraps 1111->0000, GRAY_WR_PTR 1000->0000, W_ADDR 7->0, FULL never asserts, WR_LEVEL stays 2.
- Reset mid-operation while FULL=1 and WR_LEVEL=8: RST=0 for one edge -> FULL=0, WR_LEVEL=0, GRAY_WR_PTR=0000 on that edge.

Source files
------------

// File: rtl/fifo_wr_ptr_full_if.sv
// Write-side bundle between the FIFO write controller and its producer/memory/synchronizer.
// FIFO_WR_OVF_EN adds the sticky OVERFLOW flag to the bundle.
interface fifo_wr_ptr_full_if #(
  parameter int ADD_WIDTH = 3
);
  logic                 W_INC;
  logic [ADD_WIDTH:0]   SYNC_RD_PTR;
  logic [ADD_WIDTH-1:0] W_ADDR;
  logic                 W_EN;
  logic [ADD_WIDTH:0]   GRAY_WR_PTR;
  logic                 FULL;
  logic                 ALMOST_FULL;
  logic [ADD_WIDTH:0]   WR_LEVEL;
`ifdef FIFO_WR_OVF_EN
  logic                 OVERFLOW;

  modport master (
    output W_INC, SYNC_RD_PTR,
    input  W_ADDR, W_EN, GRAY_WR_PTR, FULL, ALMOST_FULL, WR_LEVEL, OVERFLOW
  );
  modport slave (
    input  W_INC, SYNC_RD_PTR,
    output W_ADDR, W_EN, GRAY_WR_PTR, FULL, ALMOST_FULL, WR_LEVEL, OVERFLOW
  );
`else
  modport master (
    output W_INC, SYNC_RD_PTR,
    input  W_ADDR, W_EN, GRAY_WR_PTR, FULL, ALMOST_FULL, WR_LEVEL
  );
  modport slave (
    input  W_INC, SYNC_RD_PTR,
    output W_ADDR, W_EN, GRAY_WR_PTR, FULL, ALMOST_FULL, WR_LEVEL
  );
`endif
endinterface

// File: rtl/fifo_wr_ptr_full.sv
// Write-domain pointer/flag controller of the dual-clock FIFO: binary address, Gray pointer, FULL/ALMOST_FULL/level.
// Optional macro FIFO_WR_OVF_EN adds a sticky OVERFLOW output (write attempted while full).
module fifo_wr_ptr_full #(
  parameter int ADD_WIDTH = 3,
  parameter int AF_THRESH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  fifo_wr_ptr_full_if.slave     bus
);
  localparam int PW = ADD_WIDTH + 1;
  localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);
  // Gray pointer one lap ahead of the read pointer differs in exactly the top two bits.
  localparam logic [PW-1:0] TOP2 = PW'(3) << (PW - 2);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] wbin_q,  wbin_d;
  logic [PW-1:0] gray_q,  gray_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] rbin;
  logic          full_q,  full_d;
  logic          af_q,    af_d;
  logic          wen;

  always_comb begin
    wen     = bus.W_INC & ~full_q;
    wbin_d  = wbin_q + PW'(wen);
    gray_d  = bin2gray(wbin_d);
    rbin    = gray2bin(bus.SYNC_RD_PTR);
    level_d = wbin_d - rbin;
    full_d  = (gray_d == (bus.SYNC_RD_PTR ^ TOP2));
    af_d    = (level_d >= AF_T);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wbin_q  <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      full_q  <= full_d;
      af_q    <= af_d;
    end
  end

  assign bus.W_EN        = wen;
  assign bus.W_ADDR      = wbin_q[ADD_WIDTH-1:0];
  assign bus.GRAY_WR_PTR = gray_q;
  assign bus.FULL        = full_q;
  assign bus.ALMOST_FULL = af_q;
  assign bus.WR_LEVEL    = level_q;

`ifdef FIFO_WR_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (bus.W_INC & full_q);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.OVERFLOW = ovf_q;
`endif

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// Self-checking bench for fifo_wr_ptr_full: directed vector table, wraparound run, randomized run vs. counter model.
module tb_fifo_wr_ptr_full;
  localparam int AW = 3;
  localparam int AF = 6;

  logic CLK;
  logic RST;
  int   nchk;
  int   nfail;

  fifo_wr_ptr_full_if #(.ADD_WIDTH(AW)) bus ();

  fifo_wr_ptr_full #(.ADD_WIDTH(AW), .AF_THRESH(AF)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst_n;
    logic       winc;
    logic [3:0] rd;
    logic       wen;
    logic [2:0] addr;
    logic [3:0] gray;
    logic       full;
    logic       af;
    logic [3:0] lvl;
    logic       ovf;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [3:0] g4(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst_n, input logic winc, input logic [3:0] rd);
    RST             = rst_n;
    bus.W_INC       = winc;
    bus.SYNC_RD_PTR = rd;
    #1;
  endtask

  task automatic edge_settle();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_regs(input string tag, input int addr, input int gray,
                          input int full, input int af, input int lvl);
    chk({tag, ".W_ADDR"},      int'(bus.W_ADDR),      addr);
    chk({tag, ".GRAY_WR_PTR"}, int'(bus.GRAY_WR_PTR), gray);
    chk({tag, ".FULL"},        int'(bus.FULL),        full);
    chk({tag, ".ALMOST_FULL"}, int'(bus.ALMOST_FULL), af);
    chk({tag, ".WR_LEVEL"},    int'(bus.WR_LEVEL),    lvl);
  endtask

  // Model state for the randomized run: write/read entry counts modulo 16.
  int m_w, m_r, m_lvl;
  bit m_full, m_af, m_ovf;

  initial begin
    nchk = 0;
    nfail = 0;
    RST = 1'b0;
    bus.W_INC = 1'b0;
    bus.SYNC_RD_PTR = '0;

    //                rst  winc  rd       wen  addr  gray     full af  lvl   ovf
    tbl[0]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 3'd1, 4'b0001, 1'b0, 1'b0, 4'd1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 3'd2, 4'b0011, 1'b0, 1'b0, 4'd2, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 3'd3, 4'b0010, 1'b0, 1'b0, 4'd3, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 3'd4, 4'b0110, 1'b0, 1'b0, 4'd4, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 3'd5, 4'b0111, 1'b0, 1'b0, 4'd5, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 3'd6, 4'b0101, 1'b0, 1'b1, 4'd6, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 3'd7, 4'b0100, 1'b0, 1'b1, 4'd7, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 4'b0001, 1'b0, 3'd0, 4'b1100, 1'b0, 1'b1, 4'd7, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 4'b0001, 1'b1, 3'd1, 4'b1101, 1'b1, 1'b1, 4'd8, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 4'b0001, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0};

    #1;
    drive(1'b0, 1'b0, 4'b0000);
    edge_settle();
    edge_settle();
    chk_regs("init", 0, 0, 0, 0, 0);
    chk("init.W_EN", int'(bus.W_EN), 0);

    // Directed table: fill, write-while-full, drain one, refill, reset while full.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst_n, tbl[i].winc, tbl[i].rd);
      chk($sformatf("vec%0d.W_EN", i), int'(bus.W_EN), int'(tbl[i].wen));
      edge_settle();
      chk_regs($sformatf("vec%0d", i), int'(tbl[i].addr), int'(tbl[i].gray),
               int'(tbl[i].full), int'(tbl[i].af), int'(tbl[i].lvl));
`ifdef FIFO_WR_OVF_EN
      chk($sformatf("vec%0d.OVERFLOW", i), int'(bus.OVERFLOW), int'(tbl[i].ovf));
`endif
    end

    // Wraparound: 20 writes with the read pointer trailing two entries behind.
    drive(1'b0, 1'b0, 4'b0000);
    edge_settle();
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, 1'b1, g4((k >= 2) ? k - 2 : 0));
      chk($sformatf("wrap%0d.W_EN", k), int'(bus.W_EN), 1);
      edge_settle();
      chk_regs($sformatf("wrap%0d", k), k % 8, int'(g4(k % 16)), 0,
               0, (k >= 2) ? 2 : 1);
    end

    // Randomized run against a count-based model; read count never passes write count.
    drive(1'b0, 1'b0, 4'b0000);
    edge_settle();
    m_w = 0; m_r = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
    for (int c = 0; c < 600; c++) begin
      logic rn, wi;
      bit   exp_wen;
      rn = ($urandom_range(0, 63) != 0);
      wi = ($urandom_range(0, 99) < 60);
      if (((m_w - m_r) & 15) > 0 && $urandom_range(0, 99) < 45) m_r = (m_r + 1) & 15;
      drive(rn, wi, g4(m_r));
      exp_wen = wi && !m_full;
      chk("rand.W_EN", int'(bus.W_EN), int'(exp_wen));
      if (!rn) begin
        m_w = 0; m_r = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
      end else begin
        m_ovf = m_ovf | (wi && m_full);
        if (exp_wen) m_w = (m_w + 1) & 15;
        m_lvl  = (m_w - m_r) & 15;
        m_full = (m_lvl == 8);
        m_af   = (m_lvl >= AF);
      end
      edge_settle();
      chk_regs("rand", m_w % 8, int'(g4(m_w)), int'(m_full), int'(m_af), m_lvl);
`ifdef FIFO_WR_OVF_EN
      chk("rand.OVERFLOW", int'(bus.OVERFLOW), int'(m_ovf));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end
endmodule
